alu_exec_stage: RTL

Registered execute stage that sits directly upstream of the result consumer and wraps the team's 16-bit ALU datapath. It accepts operation requests over a valid/ready handshake, computes the single-cycle ops in one cycle and divide iteratively, and holds result plus flags in an output register until downstream accepts them. It also keeps a sticky overflow status bit.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_div_iter.sv | 63 ++++++
 rtl/alu_exec_stage.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encodings and the flag bundle for the ALU execute stage.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_DIV  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_DIV  = 1'b1;

  typedef struct packed {
    logic sign;
    logic zero;
    logic carry;
    logic parity;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_div_iter.sv
// Iterative restoring divider: one shift-subtract step per enabled cycle.
module alu_div_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last_c,
  output logic [WIDTH-1:0] quo_c,
  output logic             dbz
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q, quo_q, b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dbz_q;
  logic [WIDTH:0]   shifted_c, trial_c;
  logic [WIDTH-1:0] rem_n, quo_n;

  // Next remainder/quotient for one restoring step.
  always_comb begin
    shifted_c = {rem_q, quo_q[WIDTH-1]};
    trial_c   = shifted_c - {1'b0, b_q};
    rem_n     = shifted_c[WIDTH-1:0];
    quo_n     = {quo_q[WIDTH-2:0], 1'b0};
    if (!trial_c[WIDTH]) begin
      rem_n = trial_c[WIDTH-1:0];
      quo_n = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  // Operand capture on start, then one step per enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= a;
      b_q   <= b;
      cnt_q <= CNT_W'(WIDTH - 1);
      dbz_q <= (b == '0);
    end else if (step) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign last_c = (cnt_q == '0);
  assign quo_c  = quo_n;
  assign dbz    = dbz_q;

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: single-cycle ops, iterative divide, held output slot, sticky overflow.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             out_sign,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_parity,
  output logic             out_overflow,
  output logic             sticky_ovf,
  input  logic             clr_sticky,
  output logic             busy
);

  localparam int unsigned PW = 2 * WIDTH;

  state_t           state_q, state_d;
  logic             slot_free, accept;
  logic             load, div_start, div_step;
  logic             div_last, div_dbz;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH:0]   sum_c, diff_c;
  logic [PW-1:0]    prod_c;
  logic [WIDTH-1:0] z_c;
  logic             carry_c, ovf_c;
  alu_flags_t       flags_c, flags_q;

  assign slot_free = ~out_valid | out_ready;
  assign in_ready  = (state_q == ST_IDLE) & slot_free;
  assign accept    = in_valid & in_ready;
  assign busy      = (state_q == ST_DIV);

  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (div_start),
    .step   (div_step),
    .a      (in_a),
    .b      (in_b),
    .last_c (div_last),
    .quo_c  (div_quo),
    .dbz    (div_dbz)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and datapath control; divide finishes only into a free output slot.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    div_start = 1'b0;
    div_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (in_op == OP_DIV) begin
            div_start = 1'b1;
            state_d   = ST_DIV;
          end else begin
            load = 1'b1;
          end
        end
      end
      ST_DIV: begin
        if (!div_last) begin
          div_step = 1'b1;
        end else if (slot_free) begin
          div_step = 1'b1;
          load     = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Result value, carry and overflow for whichever source loads the slot.
  always_comb begin
    sum_c   = {1'b0, in_a} + {1'b0, in_b};
    diff_c  = {1'b0, in_a} - {1'b0, in_b};
    prod_c  = PW'(in_a) * PW'(in_b);
    z_c     = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    if (state_q == ST_DIV) begin
      z_c     = div_dbz ? '0 : div_quo;
      carry_c = div_dbz;
    end else begin
      case (in_op)
        OP_ADD: begin
          z_c     = sum_c[WIDTH-1:0];
          carry_c = sum_c[WIDTH];
          ovf_c   = (in_a[WIDTH-1] == in_b[WIDTH-1]) & (sum_c[WIDTH-1] != in_a[WIDTH-1]);
        end
        OP_SUB: begin
          z_c     = diff_c[WIDTH-1:0];
          carry_c = diff_c[WIDTH];
          ovf_c   = (in_a[WIDTH-1] != in_b[WIDTH-1]) & (diff_c[WIDTH-1] != in_a[WIDTH-1]);
        end
        OP_AND: z_c = in_a & in_b;
        OP_NOT: z_c = ~in_a;
        OP_MUL: begin
          z_c     = prod_c[WIDTH-1:0];
          carry_c = |prod_c[PW-1:WIDTH];
        end
        OP_XOR: z_c = in_a ^ in_b;
        default: z_c = '0;
      endcase
    end
    flags_c.sign     = z_c[WIDTH-1];
    flags_c.zero     = ~|z_c;
    flags_c.carry    = carry_c;
    flags_c.parity   = ~^z_c;
    flags_c.overflow = ovf_c;
  end

  // Output slot: load new result, otherwise drain on downstream accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_z     <= '0;
      flags_q   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_z     <= z_c;
      flags_q   <= flags_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky overflow; a loading overflow result beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        sticky_ovf <= 1'b0;
    else if (load && flags_c.overflow) sticky_ovf <= 1'b1;
    else if (clr_sticky)               sticky_ovf <= 1'b0;
  end

  assign out_sign     = flags_q.sign;
  assign out_zero     = flags_q.zero;
  assign out_carry    = flags_q.carry;
  assign out_parity   = flags_q.parity;
  assign out_overflow = flags_q.overflow;

endmodule
